// File: rtl/hamming_pkg.sv
// Shared definitions for the parametrised SEC-DED Hamming codec family.
// Holds parity-width derivation, codeword layout helpers and the
// decode classification used by the decoder's second stage.
package hamming_pkg;

  // Width of the saturating error counters.
  localparam int unsigned CNT_W = 16;

  // Outcome of examining syndrome S and overall parity P.
  typedef enum logic [1:0] {
    DEC_CLEAN   = 2'd0,  // S=0, P=0
    DEC_FIX_PAR = 2'd1,  // S=0, P=1: only the overall parity bit is wrong
    DEC_FIX_BIT = 2'd2,  // P=1, S a valid position: flip bit S-1
    DEC_DOUBLE  = 2'd3   // uncorrectable
  } dec_class_e;

  // Smallest r with 2^r >= data_w + r + 1 (data_w up to 64 needs r <= 7).
  function automatic int unsigned par_w(input int unsigned data_w);
    int unsigned res;
    res = 8;
    for (int unsigned r = 7; r >= 1; r--) begin
      if ((32'd1 << r) >= data_w + r + 1) res = r;
    end
    return res;
  endfunction

  // True for Hamming positions 1, 2, 4, ... (the parity positions).
  function automatic logic is_pow2(input int unsigned pos);
    return (pos != 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Codeword bit index of data bit k: data bits fill the non-power-of-two
  // Hamming positions in ascending order, and bit index = position - 1.
  function automatic int unsigned data_pos(input int unsigned k);
    int unsigned cnt;
    int unsigned res;
    logic        found;
    cnt   = 0;
    res   = 0;
    found = 1'b0;
    for (int unsigned pos = 1; pos <= 128; pos++) begin
      if (!found && !is_pow2(pos)) begin
        if (cnt == k) begin
          res   = pos - 1;
          found = 1'b1;
        end
        cnt++;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome / overall-parity generator for a SEC-DED codeword.
// S is the XOR of the Hamming positions of every set bit below the overall
// parity bit; P is the XOR of the whole codeword. Shared with the encoder.
module hamming_syndrome
  import hamming_pkg::*;
#(
  parameter  int unsigned DATA_W = 4,
  localparam int unsigned PAR_W  = par_w(DATA_W),
  localparam int unsigned CW_W   = DATA_W + PAR_W + 1
) (
  input  logic [CW_W-1:0]  cw,
  output logic [PAR_W-1:0] syn,
  output logic             par
);

  // Accumulate the position of each set bit into the syndrome.
  always_comb begin
    syn = '0;
    for (int unsigned i = 0; i < CW_W - 1; i++) begin
      if (cw[i]) syn = syn ^ PAR_W'(i + 1);
    end
  end

  // Even parity over the full codeword, overall parity bit included.
  always_comb begin
    par = ^cw;
  end

endmodule

// File: rtl/hamming_secded_decoder.sv
// Streaming two-stage SEC-DED Hamming decoder with valid/ready handshake.
// Stage 1 registers syndrome, overall parity and the raw codeword; stage 2
// registers corrected payload and status. Optional error counters are
// built when SECDED_ERR_CNT_EN is defined; otherwise they read as zero.
module hamming_secded_decoder
  import hamming_pkg::*;
#(
  parameter  int unsigned DATA_W = 4,
  localparam int unsigned PAR_W  = par_w(DATA_W),
  localparam int unsigned CW_W   = DATA_W + PAR_W + 1,
  localparam int unsigned POS_W  = $clog2(CW_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   in_cw,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err_single,
  output logic              out_err_double,
  output logic [POS_W-1:0]  out_err_pos,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_single,
  output logic [CNT_W-1:0]  cnt_double
);

  // Mask of codeword bits that carry payload.
  function automatic logic [CW_W-1:0] data_mask();
    logic [CW_W-1:0] m;
    m = '0;
    for (int unsigned k = 0; k < DATA_W; k++) m[data_pos(k)] = 1'b1;
    return m;
  endfunction

  localparam logic [CW_W-1:0] DATA_MASK = data_mask();

  logic              s1_valid;
  logic [CW_W-1:0]   s1_cw;
  logic [PAR_W-1:0]  s1_syn;
  logic              s1_par;

  logic [PAR_W-1:0]  in_syn;
  logic              in_par;

  logic              s1_adv;
  logic              s2_adv;
  logic              out_xfer;

  dec_class_e        dec_class;
  logic [DATA_W-1:0] dec_data;
  logic              dec_single;
  logic              dec_double;
  logic [POS_W-1:0]  dec_pos;
  logic              fix_bit;
  logic              unused_cw_bits;

  hamming_syndrome #(
    .DATA_W (DATA_W)
  ) u_syndrome (
    .cw  (in_cw),
    .syn (in_syn),
    .par (in_par)
  );

  // Pipeline advance conditions; in_ready follows out_ready combinationally.
  always_comb begin
    s2_adv   = !out_valid || out_ready;
    s1_adv   = !s1_valid || s2_adv;
    in_ready = s1_adv;
    out_xfer = out_valid && out_ready;
  end

  // Stage 1: capture syndrome, parity and raw codeword on input transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_cw    <= '0;
      s1_syn   <= '0;
      s1_par   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_cw  <= in_cw;
        s1_syn <= in_syn;
        s1_par <= in_par;
      end
    end
  end

  // Classify the stage-1 word from S and P.
  always_comb begin
    dec_class = DEC_CLEAN;
    if (s1_par) begin
      if (s1_syn == '0)                  dec_class = DEC_FIX_PAR;
      else if (32'(s1_syn) <= CW_W - 1)  dec_class = DEC_FIX_BIT;
      else                               dec_class = DEC_DOUBLE;
    end else if (s1_syn != '0) begin
      dec_class = DEC_DOUBLE;
    end
  end

  // Status flags and corrected position for the classified word.
  always_comb begin
    dec_single = 1'b0;
    dec_double = 1'b0;
    dec_pos    = '0;
    fix_bit    = 1'b0;
    unique case (dec_class)
      DEC_CLEAN: ;
      DEC_FIX_PAR: begin
        dec_single = 1'b1;
        dec_pos    = POS_W'(CW_W - 1);
      end
      DEC_FIX_BIT: begin
        dec_single = 1'b1;
        fix_bit    = 1'b1;
        dec_pos    = POS_W'(s1_syn - PAR_W'(1));
      end
      DEC_DOUBLE: dec_double = 1'b1;
      default: ;
    endcase
  end

  // Only payload bits are extracted; a correction flips a data bit when the
  // syndrome names that bit's Hamming position, so no full-width flip mask
  // is needed.
  for (genvar k = 0; k < DATA_W; k++) begin : g_extract
    localparam int unsigned DP = data_pos(k);
    assign dec_data[k] = s1_cw[DP] ^ (fix_bit && (s1_syn == PAR_W'(DP + 1)));
  end

  // Parity positions of the raw codeword are not needed after stage 1.
  assign unused_cw_bits = ^(s1_cw & ~DATA_MASK);

  // Stage 2: register decoded result; holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_err_single <= 1'b0;
      out_err_double <= 1'b0;
      out_err_pos    <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data       <= dec_data;
        out_err_single <= dec_single;
        out_err_double <= dec_double;
        out_err_pos    <= dec_pos;
      end
    end
  end

`ifdef SECDED_ERR_CNT_EN
  // Saturating corrected-error counter; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                             cnt_single <= '0;
    else if (cnt_clr)                                    cnt_single <= '0;
    else if (out_xfer && out_err_single && cnt_single != '1) cnt_single <= cnt_single + 1'b1;
  end

  // Saturating uncorrectable-error counter; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                             cnt_double <= '0;
    else if (cnt_clr)                                    cnt_double <= '0;
    else if (out_xfer && out_err_double && cnt_double != '1) cnt_double <= cnt_double + 1'b1;
  end
`else
  logic unused_cnt_clr;

  // Counters absent: outputs tied low, clear input ignored.
  always_comb begin
    cnt_single     = '0;
    cnt_double     = '0;
    unused_cnt_clr = cnt_clr ^ out_xfer;
  end
`endif

endmodule
